// File: rtl/pc_redirect_unit_if.sv
// Fetch-side bundle between the PC owner and its request sources (branch unit, decode, hazard unit).
// The master modport drives requests and observes the PC; the slave modport is the PC owner.
interface pc_redirect_unit_if;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        JumpTaken;
  logic [31:0] JumpTarget;
  logic [31:0] PCResult;
  logic [31:0] PCPlus4;
  logic        Flush;
  logic        RedirectPending;
  logic        Misaligned;
  logic [15:0] RedirectCount;

  modport master (
    output Stall, BranchTaken, BranchTarget, JumpTaken, JumpTarget,
    input  PCResult, PCPlus4, Flush, RedirectPending, Misaligned, RedirectCount
  );

  modport slave (
    input  Stall, BranchTaken, BranchTarget, JumpTaken, JumpTarget,
    output PCResult, PCPlus4, Flush, RedirectPending, Misaligned, RedirectCount
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// Program-counter owner: steps the PC, applies branch/jump redirects, and buffers a
// redirect that arrives during a stall until the stall releases.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic               Clk,
  input  logic               Reset,
  pc_redirect_unit_if.slave  bus
);

  typedef enum logic [0:0] {IDLE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] held_q, held_d;
  logic        flush_q, flush_d;
  logic        mis_q, mis_d;
  logic [15:0] cnt_q, cnt_d;

  logic        req;
  logic [31:0] sel_raw;
  logic [31:0] sel_tgt;
  logic [31:0] br_tgt;
  logic [15:0] cnt_inc;

  always_comb begin
    req     = bus.BranchTaken | bus.JumpTaken;
    // Branch wins over jump: it is the older instruction in the pipe.
    sel_raw = bus.BranchTaken ? bus.BranchTarget : bus.JumpTarget;
    sel_tgt = {sel_raw[31:2], 2'b00};
    br_tgt  = {bus.BranchTarget[31:2], 2'b00};
    cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    state_d = state_q;
    pc_d    = pc_q;
    held_d  = held_q;
    flush_d = 1'b0;
    mis_d   = mis_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (sel_raw[1:0] != 2'b00) mis_d = 1'b1;
          if (!bus.Stall) begin
            pc_d    = sel_tgt;
            flush_d = 1'b1;
            cnt_d   = cnt_inc;
          end else begin
            held_d  = sel_tgt;
            state_d = HOLD;
          end
        end else if (!bus.Stall) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      HOLD: begin
        // Only a younger-than-held branch can displace the buffered target; jumps are dropped.
        if (bus.BranchTaken && bus.BranchTarget[1:0] != 2'b00) mis_d = 1'b1;
        if (bus.Stall) begin
          if (bus.BranchTaken) held_d = br_tgt;
        end else begin
          pc_d    = bus.BranchTaken ? br_tgt : held_q;
          flush_d = 1'b1;
          cnt_d   = cnt_inc;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      held_q  <= 32'h0000_0000;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      held_q  <= held_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.PCResult        = pc_q;
  assign bus.PCPlus4         = pc_q + PC_STEP;
  assign bus.Flush           = flush_q;
  assign bus.RedirectPending = (state_q == HOLD);
  assign bus.Misaligned      = mis_q;
  assign bus.RedirectCount   = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed vector table for pc_redirect_unit plus a counter-saturation sequence.
module tb_pc_redirect_unit;

  logic clk;
  logic rst;

  pc_redirect_unit_if bus ();

  pc_redirect_unit #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (32'd4)
  ) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        bt;
    logic [31:0] btgt;
    logic        jt;
    logic [31:0] jtgt;
    logic [31:0] e_pc;
    logic        e_flush;
    logic        e_pend;
    logic        e_mis;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic s, input logic b, input logic [31:0] bt_t,
                     input logic j, input logic [31:0] jt_t, input logic [31:0] pc,
                     input logic fl, input logic pd, input logic ms, input logic [15:0] cn);
    vec_t v;
    v.rst = r; v.stall = s; v.bt = b; v.btgt = bt_t; v.jt = j; v.jtgt = jt_t;
    v.e_pc = pc; v.e_flush = fl; v.e_pend = pd; v.e_mis = ms; v.e_cnt = cn;
    vecs.push_back(v);
  endtask

  task automatic chk32(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] bt_t,
                       input logic j, input logic [31:0] jt_t);
    rst = r;
    bus.Stall = s;
    bus.BranchTaken = b;
    bus.BranchTarget = bt_t;
    bus.JumpTaken = j;
    bus.JumpTarget = jt_t;
  endtask

  initial begin
    // Reset, then plain sequential stepping up to PC=0x20.
    add(1, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 32'h4,   0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 32'h8,   0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 32'hC,   0, 0, 0, 0);
    for (int k = 1; k <= 5; k++)
      add(0, 0, 0, 0, 0, 0, 32'hC + 32'(4 * k), 0, 0, 0, 0);
    // Branch beats simultaneous jump.
    add(0, 0, 1, 32'h100, 1, 32'h200, 32'h100, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 32'h104, 0, 0, 0, 1);
    // Redirect buffered across a 3-cycle stall.
    add(0, 1, 1, 32'h80, 0, 0, 32'h104, 0, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0, 32'h104, 0, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0, 32'h104, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 32'h80,  1, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 32'h84,  0, 0, 0, 2);
    // In HOLD: newer branch replaces held target, jump ignored.
    add(0, 1, 1, 32'h80, 0, 0, 32'h84, 0, 1, 0, 2);
    add(0, 1, 1, 32'h90, 0, 0, 32'h84, 0, 1, 0, 2);
    add(0, 1, 0, 0, 1, 32'h300, 32'h84, 0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 32'h90, 1, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 32'h94, 0, 0, 0, 3);
    // Misaligned target is aligned and the flag sticks.
    add(0, 0, 1, 32'h103, 0, 0, 32'h100, 1, 0, 1, 4);
    for (int k = 1; k <= 10; k++)
      add(0, 0, 0, 0, 0, 0, 32'h100 + 32'(4 * k), 0, 0, 1, 4);
    add(1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    // Wrap-around of the PC.
    add(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1);
    // Reset during HOLD discards the held target.
    add(0, 0, 0, 0, 0, 0, 32'h4, 0, 0, 0, 1);
    add(0, 1, 1, 32'h40, 0, 0, 32'h4, 0, 1, 0, 1);
    add(1, 1, 1, 32'h44, 0, 0, 32'h0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 32'h4, 0, 0, 0, 0);
    // Redirect on the edge the stall drops from IDLE is applied directly.
    add(0, 1, 0, 0, 0, 0, 32'h4, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 32'h50, 32'h50, 1, 0, 0, 1);
    // Misaligned jump latched into HOLD sets the flag immediately.
    add(0, 1, 0, 0, 1, 32'h61, 32'h50, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 32'h60, 1, 0, 1, 2);
    // Back-to-back redirects give back-to-back flushes.
    add(0, 0, 1, 32'h70, 0, 0, 32'h70, 1, 0, 1, 3);
    add(0, 0, 0, 0, 0, 0, 32'h74, 0, 0, 1, 3);

    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].stall, vecs[i].bt, vecs[i].btgt, vecs[i].jt, vecs[i].jtgt);
      @(posedge clk);
      #1;
      chk32("PCResult",        i, bus.PCResult,                 vecs[i].e_pc);
      chk32("PCPlus4",         i, bus.PCPlus4,                  vecs[i].e_pc + 32'd4);
      chk32("Flush",           i, {31'b0, bus.Flush},           {31'b0, vecs[i].e_flush});
      chk32("RedirectPending", i, {31'b0, bus.RedirectPending}, {31'b0, vecs[i].e_pend});
      chk32("Misaligned",      i, {31'b0, bus.Misaligned},      {31'b0, vecs[i].e_mis});
      chk32("RedirectCount",   i, {16'b0, bus.RedirectCount},   {16'b0, vecs[i].e_cnt});
      $display("vec %0d rst=%0b stall=%0b bt=%0b jt=%0b pc=%h flush=%0b pend=%0b mis=%0b cnt=%0d",
               i, vecs[i].rst, vecs[i].stall, vecs[i].bt, vecs[i].jt, bus.PCResult,
               bus.Flush, bus.RedirectPending, bus.Misaligned, bus.RedirectCount);
    end

    // Saturation: count starts at 3, run well past 65535 applied redirects.
    for (int n = 0; n < 65540; n++) begin
      @(negedge clk);
      drive(0, 0, 1, 32'h0000_0200 + 32'((n % 4) * 4), 0, 0);
      @(posedge clk);
      #1;
      if (n == 65531) begin
        chk32("RedirectCount_reach", n, {16'b0, bus.RedirectCount}, 32'h0000_FFFF);
        $display("sat n=%0d cnt=%h", n, bus.RedirectCount);
      end
    end
    chk32("RedirectCount_sat", 65540, {16'b0, bus.RedirectCount}, 32'h0000_FFFF);
    chk32("Flush_sat",         65540, {31'b0, bus.Flush}, 32'h1);
    chk32("PCResult_sat",      65540, bus.PCResult, 32'h0000_020C);
    $display("sat final cnt=%h pc=%h flush=%0b", bus.RedirectCount, bus.PCResult, bus.Flush);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Program-counter owner for the fetch stage: it consumes the branch target from the PC+immediate adder and the jump target from decode, and holds the PC. It also produces PC+4 and sequences redirects against pipeline stalls. A redirect requested while the pipeline is stalled is buffered and applied when the stall releases. Each applied redirect produces a one-cycle flush pulse for the IF/ID register.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- PC_STEP, 4, sequential increment added to PC each non-stalled cycle
- Clk  input  1  rising-edge clock for all state
- Reset  input  1  synchronous, active-high; overrides every other input
- Stall  input  1  hazard unit hold; PC must not change while high
- BranchTaken  input  1  EX-stage branch resolved taken this cycle
- BranchTarget  input  32  branch target from the PC+immediate adder
- JumpTaken  input  1  ID-stage unconditional jump this cycle
- JumpTarget  input  32  jump target from decode
- PCResult  output  32  current PC (registered)
- PCPlus4  output  32  PCResult + PC_STEP (combinational from PCResult)
- Flush  output  1  registered one-cycle pulse; squash IF/ID
- RedirectPending  output  1  high while a redirect is buffered (state HOLD)
- Misaligned  output  1  sticky; a target with bits [1:0] != 0 was accepted
- RedirectCount  output  16  applied redirects, saturating

## Operation
- Request selection: BranchTaken has priority over JumpTaken because the branch is older. The selected target is T with T[1:0] forced to 2'b00. If the raw target had nonzero low bits, Misaligned is set and stays set until Reset.
- States: IDLE and HOLD.
- IDLE, Stall=0, request present: PCResult <= T; Flush <= 1; RedirectCount += 1; stay in IDLE.
- IDLE, Stall=0, no request: PCResult <= PCResult + PC_STEP; Flush <= 0.
- IDLE, Stall=1, request present: latch T into the held-target register; go to HOLD; PC unchanged; Flush <= 0.
- IDLE, Stall=1, no request: PC unchanged; Flush <= 0.
- HOLD, Stall=1: PC unchanged. A new BranchTaken replaces the held target. JumpTaken is ignored.
- HOLD, Stall=0: PCResult <= held target, or the current BranchTarget if BranchTaken is high that cycle. Flush <= 1; RedirectCount += 1; go to IDLE. JumpTaken is ignored in this cycle.
- RedirectPending = (state == HOLD).
- Arithmetic:
  - All PC math is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000, with no flag.
  - RedirectCount saturates at 16'hFFFF and does not wrap.
- Misaligned is set in the cycle a misaligned target is selected, including when it is only latched into HOLD.

## Timing
- Reset values: PCResult = RESET_PC, PCPlus4 = RESET_PC + PC_STEP, Flush = 0, RedirectPending = 0, Misaligned = 0, RedirectCount = 0, state = IDLE.
- Reset asserted during HOLD discards the held target. There is no flush pulse on reset.
- Redirect latency with no stall:
  - Request sampled at edge N, so PCResult = T after edge N.
  - Flush is high for the single cycle between edges N and N+1.
- Redirect latency with stall: PCResult = T after the first edge that samples Stall=0. Flush is high for that one cycle only.
- Flush is never high for two consecutive cycles unless two redirects are applied on consecutive edges.
- A redirect on the very edge where Stall falls from IDLE is handled as the IDLE, Stall=0 case: applied directly, never buffered.
- PCPlus4 tracks PCResult in the same cycle, with zero added latency.

## Test plan
- Reset, then 3 unstalled cycles: PCResult sequence 0 -> 4 -> 8 -> C, PCPlus4 = 10 in the last cycle, Flush stays 0.
- PC = 0x20; BranchTaken=1, BranchTarget=0x100, JumpTaken=1, JumpTarget=0x200 at one edge:
  - PCResult = 0x100 and Flush = 1 for one cycle.
  - RedirectCount = 1; next PC = 0x104.
- Stall=1, BranchTaken=1, target 0x80, for one cycle, then Stall held 2 more cycles with no requests, then Stall=0:
  - RedirectPending = 1 for 3 cycles and the PC is frozen.
  - PCResult = 0x80 after release; Flush pulses once; RedirectPending = 0.
- While in HOLD with 0x80 held, BranchTaken with target 0x90, then JumpTaken with target 0x300, then Stall=0: PCResult = 0x90, the jump is ignored, and RedirectCount increments by exactly 1.
- BranchTarget = 0x103, Stall=0: PCResult = 0x100; Misaligned = 1 and remains 1 for the following 10 cycles; Reset clears it.
- PC forced to 0xFFFF_FFFC by branch, then one unstalled cycle: PCResult = 0x0. Reset asserted while in HOLD returns PCResult = RESET_PC, RedirectPending = 0, Flush = 0.
